// File: rtl/alu_iqueue_mw.sv
// alu_iqueue_mw: age-ordered ALU issue queue with multi-port dispatch,
// broadcast wakeup and oldest-first multi-port select.
module alu_iqueue_mw #(
  parameter int QLEN      = 16,
  parameter int WRITE_NUM = 2,
  parameter int ISSUE_NUM = 2,
  parameter int WAKE_NUM  = 4,
  parameter int PREG_W    = 6,
  parameter int AGE_W     = 7,
  parameter int PAYLOAD_W = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [WRITE_NUM-1:0]                 wr_valid,
  input  logic [WRITE_NUM-1:0][AGE_W-1:0]      wr_age,
  input  logic [WRITE_NUM-1:0][PREG_W-1:0]     wr_s1,
  input  logic [WRITE_NUM-1:0][PREG_W-1:0]     wr_s2,
  input  logic [WRITE_NUM-1:0]                 wr_r1,
  input  logic [WRITE_NUM-1:0]                 wr_r2,
  input  logic [WRITE_NUM-1:0][PAYLOAD_W-1:0]  wr_payload,
  input  logic [WAKE_NUM-1:0]                  wake_valid,
  input  logic [WAKE_NUM-1:0][PREG_W-1:0]      wake_id,
  input  logic [ISSUE_NUM-1:0]                 iss_ready,
  output logic [ISSUE_NUM-1:0]                 iss_valid,
  output logic [ISSUE_NUM-1:0][AGE_W-1:0]      iss_age,
  output logic [ISSUE_NUM-1:0][PREG_W-1:0]     iss_s1,
  output logic [ISSUE_NUM-1:0][PREG_W-1:0]     iss_s2,
  output logic [ISSUE_NUM-1:0][PAYLOAD_W-1:0]  iss_payload,
  output logic                                 full,
  output logic [$clog2(QLEN):0]                count
);

  localparam int IDX_W = $clog2(QLEN);
  localparam int CNT_W = IDX_W + 1;
  localparam int WP_W  = (WRITE_NUM > 1) ? $clog2(WRITE_NUM) : 1;

  logic [QLEN-1:0]                v_q, v_d;
  logic [QLEN-1:0]                r1_q, r1_d;
  logic [QLEN-1:0]                r2_q, r2_d;
  logic [QLEN-1:0][AGE_W-1:0]     age_q, age_d;
  logic [QLEN-1:0][PREG_W-1:0]    s1_q, s1_d;
  logic [QLEN-1:0][PREG_W-1:0]    s2_q, s2_d;
  logic [QLEN-1:0][PAYLOAD_W-1:0] pl_q, pl_d;

  logic [QLEN-1:0]                elig;
  logic [QLEN-1:0]                iss_clr;
  logic [QLEN-1:0]                wset;
  logic [QLEN-1:0][WP_W-1:0]      wport;
  logic [QLEN-1:0]                m1, m2;
  logic [WRITE_NUM-1:0]           wm1, wm2;
  logic [ISSUE_NUM-1:0][IDX_W-1:0] sel_idx;

  // a older than b; the wrap bit flips the sense of the low compare
  function automatic logic older(
    input logic [AGE_W-1:0] a,
    input logic [AGE_W-1:0] b
  );
    return (a[AGE_W-1] == b[AGE_W-1]) ^
           (a[AGE_W-2:0] > b[AGE_W-2:0]);
  endfunction

  // heap-ordered tournament; left child wins ties so lower index wins
  function automatic logic [IDX_W:0] pick_oldest(
    input logic [QLEN-1:0]            c,
    input logic [QLEN-1:0][AGE_W-1:0] a
  );
    logic [2*QLEN-1:0]            tv;
    logic [2*QLEN-1:0][IDX_W-1:0] ti;
    logic [2*QLEN-1:0][AGE_W-1:0] ta;
    tv = '0;
    ti = '0;
    ta = '0;
    for (int i = 0; i < QLEN; i++) begin
      tv[QLEN+i] = c[i];
      ti[QLEN+i] = IDX_W'(i);
      ta[QLEN+i] = a[i];
    end
    for (int n = QLEN - 1; n >= 1; n--) begin
      if (tv[2*n+1] &&
          (!tv[2*n] || !older(ta[2*n], ta[2*n+1]))) begin
        tv[n] = 1'b1;
        ti[n] = ti[2*n+1];
        ta[n] = ta[2*n+1];
      end else begin
        tv[n] = tv[2*n];
        ti[n] = ti[2*n];
        ta[n] = ta[2*n];
      end
    end
    return {tv[1], ti[1]};
  endfunction

  assign elig = v_q & r1_q & r2_q;

  always_comb begin
    logic [QLEN-1:0]  taken;
    logic [IDX_W:0]   res;
    taken     = '0;
    res       = '0;
    iss_valid = '0;
    sel_idx   = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      res          = pick_oldest(elig & ~taken, age_q);
      iss_valid[k] = res[IDX_W];
      sel_idx[k]   = res[IDX_W-1:0];
      if (res[IDX_W]) taken[res[IDX_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    iss_age     = '0;
    iss_s1      = '0;
    iss_s2      = '0;
    iss_payload = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      iss_age[k]     = age_q[sel_idx[k]];
      iss_s1[k]      = s1_q[sel_idx[k]];
      iss_s2[k]      = s2_q[sel_idx[k]];
      iss_payload[k] = pl_q[sel_idx[k]];
    end
  end

  always_comb begin
    iss_clr = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      if (iss_valid[k] && iss_ready[k])
        iss_clr[sel_idx[k]] = 1'b1;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < QLEN; i++)
      count = count + CNT_W'(v_q[i]);
  end

  assign full = (CNT_W'(QLEN) - count) < CNT_W'(WRITE_NUM);

  // pack valid write ports into lowest free slots; full gates all of them
  always_comb begin
    logic found;
    found = 1'b0;
    wset  = '0;
    wport = '0;
    for (int p = 0; p < WRITE_NUM; p++) begin
      found = 1'b0;
      if (wr_valid[p] && !full) begin
        for (int i = 0; i < QLEN; i++) begin
          if (!found && !v_q[i] && !wset[i]) begin
            wset[i]  = 1'b1;
            wport[i] = WP_W'(p);
            found    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    m1  = '0;
    m2  = '0;
    wm1 = '0;
    wm2 = '0;
    for (int j = 0; j < WAKE_NUM; j++) begin
      if (wake_valid[j]) begin
        for (int i = 0; i < QLEN; i++) begin
          if (wake_id[j] == s1_q[i]) m1[i] = 1'b1;
          if (wake_id[j] == s2_q[i]) m2[i] = 1'b1;
        end
        for (int p = 0; p < WRITE_NUM; p++) begin
          if (wake_id[j] == wr_s1[p]) wm1[p] = 1'b1;
          if (wake_id[j] == wr_s2[p]) wm2[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    v_d   = (v_q & ~iss_clr) | wset;
    r1_d  = r1_q | m1;
    r2_d  = r2_q | m2;
    age_d = age_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    pl_d  = pl_q;
    if (flush) v_d = '0;
    for (int i = 0; i < QLEN; i++) begin
      if (wset[i]) begin
        age_d[i] = wr_age[wport[i]];
        s1_d[i]  = wr_s1[wport[i]];
        s2_d[i]  = wr_s2[wport[i]];
        pl_d[i]  = wr_payload[wport[i]];
        r1_d[i]  = wr_r1[wport[i]] | wm1[wport[i]];
        r2_d[i]  = wr_r2[wport[i]] | wm2[wport[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) v_q <= '0;
    else       v_q <= v_d;
  end

  always_ff @(posedge clk) begin
    r1_q  <= r1_d;
    r2_q  <= r2_d;
    age_q <= age_d;
    s1_q  <= s1_d;
    s2_q  <= s2_d;
    pl_q  <= pl_d;
  end

endmodule

// File: tb/tb_alu_iqueue_mw.sv
// tb_alu_iqueue_mw: scoreboard bench for the ALU issue queue;
// reference model orders entries by unwrapped sequence number.
module tb_alu_iqueue_mw;

  localparam int QLEN = 16;
  localparam int WN   = 2;
  localparam int IN   = 2;
  localparam int KN   = 4;
  localparam int PW   = 6;
  localparam int AW   = 7;
  localparam int DW   = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [WN-1:0]          wr_valid;
  logic [WN-1:0][AW-1:0]  wr_age;
  logic [WN-1:0][PW-1:0]  wr_s1;
  logic [WN-1:0][PW-1:0]  wr_s2;
  logic [WN-1:0]          wr_r1;
  logic [WN-1:0]          wr_r2;
  logic [WN-1:0][DW-1:0]  wr_payload;
  logic [KN-1:0]          wake_valid;
  logic [KN-1:0][PW-1:0]  wake_id;
  logic [IN-1:0]          iss_ready;
  logic [IN-1:0]          iss_valid;
  logic [IN-1:0][AW-1:0]  iss_age;
  logic [IN-1:0][PW-1:0]  iss_s1;
  logic [IN-1:0][PW-1:0]  iss_s2;
  logic [IN-1:0][DW-1:0]  iss_payload;
  logic                   full;
  logic [4:0]             count;

  always #5 clk = ~clk;

  alu_iqueue_mw dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_age     (wr_age),
    .wr_s1      (wr_s1),
    .wr_s2      (wr_s2),
    .wr_r1      (wr_r1),
    .wr_r2      (wr_r2),
    .wr_payload (wr_payload),
    .wake_valid (wake_valid),
    .wake_id    (wake_id),
    .iss_ready  (iss_ready),
    .iss_valid  (iss_valid),
    .iss_age    (iss_age),
    .iss_s1     (iss_s1),
    .iss_s2     (iss_s2),
    .iss_payload(iss_payload),
    .full       (full),
    .count      (count)
  );

  typedef struct {
    int          seq;
    logic [PW-1:0] s1;
    logic [PW-1:0] s2;
    bit          r1;
    bit          r2;
    logic [DW-1:0] pl;
  } ent_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [AW-1:0] age;
    logic [PW-1:0] s1;
    logic [PW-1:0] s2;
    logic [DW-1:0] pl;
  } exp_t;

  typedef struct {
    int cyc;
    int cnt;
    bit fl;
  } occ_t;

  ent_t mdl[$];
  exp_t exp_q[$];
  occ_t occ_q[$];
  int   wr_seq[WN];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, req);
    end
  endtask

  function automatic bit woke(logic [PW-1:0] s);
    for (int j = 0; j < KN; j++)
      if (wake_valid[j] && wake_id[j] == s) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: pops expectations whenever the DUT presents an issue
  initial begin
    forever begin
      occ_t o;
      exp_t e;
      @(negedge clk);
      if (occ_q.size() > 0) begin
        o = occ_q.pop_front();
        chk("count", 64'(count), 64'(o.cnt));
        chk("full", 64'(full), 64'(o.fl));
        for (int k = 0; k < IN; k++) begin
          if (iss_valid[k] === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != o.cyc) begin
              total++;
              bad++;
              $display("FAIL unexpected_issue cyc=%0d port=%0d got=%0h want=none",
                       o.cyc, k, iss_age[k]);
            end else begin
              e = exp_q.pop_front();
              chk("iss_port", 64'(k), 64'(e.port));
              chk("iss_age", 64'(iss_age[k]), 64'(e.age));
              chk("iss_s1", 64'(iss_s1[k]), 64'(e.s1));
              chk("iss_s2", 64'(iss_s2[k]), 64'(e.s2));
              chk("iss_payload", iss_payload[k], e.pl);
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == o.cyc) begin
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_issue cyc=%0d port=%0d got=none want=%0h",
                   o.cyc, e.port, e.age);
        end
      end
    end
  end

  // one clock: push expected outputs, advance the model, step the DUT
  task automatic cycle();
    int   el[$];
    int   pick[IN];
    ent_t nx[$];
    ent_t e;
    exp_t x;
    bit   fl;
    bit   gone;
    el = {};
    nx = {};
    for (int i = 0; i < mdl.size(); i++)
      if (mdl[i].r1 && mdl[i].r2) el.push_back(i);
    for (int k = 0; k < IN; k++) begin
      int bj;
      bj = -1;
      pick[k] = -1;
      for (int j = 0; j < el.size(); j++)
        if (bj < 0 || mdl[el[j]].seq < mdl[el[bj]].seq) bj = j;
      if (bj >= 0) begin
        pick[k] = el[bj];
        el.delete(bj);
        x.cyc  = cyc;
        x.port = k;
        x.age  = AW'(mdl[pick[k]].seq);
        x.s1   = mdl[pick[k]].s1;
        x.s2   = mdl[pick[k]].s2;
        x.pl   = mdl[pick[k]].pl;
        exp_q.push_back(x);
      end
    end
    fl = (QLEN - mdl.size()) < WN;
    occ_q.push_back('{cyc, mdl.size(), fl});
    if (!(reset || flush)) begin
      for (int i = 0; i < mdl.size(); i++) begin
        e = mdl[i];
        gone = 1'b0;
        for (int k = 0; k < IN; k++)
          if (pick[k] == i && iss_ready[k]) gone = 1'b1;
        if (!gone) begin
          if (woke(e.s1)) e.r1 = 1'b1;
          if (woke(e.s2)) e.r2 = 1'b1;
          nx.push_back(e);
        end
      end
      if (!fl) begin
        for (int p = 0; p < WN; p++) begin
          if (wr_valid[p]) begin
            e.seq = wr_seq[p];
            e.s1  = wr_s1[p];
            e.s2  = wr_s2[p];
            e.r1  = wr_r1[p] | woke(wr_s1[p]);
            e.r2  = wr_r2[p] | woke(wr_s2[p]);
            e.pl  = wr_payload[p];
            nx.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    mdl = nx;
    cyc++;
  endtask

  task automatic idle();
    flush      = 1'b0;
    wr_valid   = '0;
    wr_age     = '0;
    wr_s1      = '0;
    wr_s2      = '0;
    wr_r1      = '0;
    wr_r2      = '0;
    wr_payload = '0;
    wake_valid = '0;
    wake_id    = '0;
    iss_ready  = '0;
  endtask

  task automatic set_wr(int p, int sq, int a, int b,
                        bit ra, bit rb);
    wr_valid[p]   = 1'b1;
    wr_seq[p]     = sq;
    wr_age[p]     = AW'(sq);
    wr_s1[p]      = PW'(a);
    wr_s2[p]      = PW'(b);
    wr_r1[p]      = ra;
    wr_r2[p]      = rb;
    wr_payload[p] = {$urandom, $urandom};
  endtask

  function automatic int min_seq(int dflt);
    int m;
    m = dflt;
    foreach (mdl[i]) if (mdl[i].seq < m) m = mdl[i].seq;
    return m;
  endfunction

  initial begin
    int seq;
    int nseq;
    int ms;
    bit fl;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset then idle
    repeat (10) cycle();

    // ages 5 and 3, both ready
    set_wr(0, 5, 1, 2, 1, 1);
    set_wr(1, 3, 3, 4, 1, 1);
    cycle();
    idle();
    iss_ready = 2'b11;
    cycle();
    idle();
    cycle();

    // wrap: 0x7E older than 0x01
    set_wr(0, 129, 5, 6, 1, 1);
    set_wr(1, 126, 7, 8, 1, 1);
    cycle();
    idle();
    iss_ready = 2'b01;
    cycle();
    iss_ready = 2'b11;
    cycle();
    idle();
    cycle();

    // wake two cycles after write
    set_wr(0, 4, 9, 10, 0, 1);
    cycle();
    idle();
    cycle();
    wake_valid[0] = 1'b1;
    wake_id[0]    = 6'd9;
    cycle();
    idle();
    iss_ready = 2'b01;
    cycle();
    cycle();

    // write and wake in the same cycle
    set_wr(0, 6, 9, 10, 0, 1);
    wake_valid[2] = 1'b1;
    wake_id[2]    = 6'd9;
    cycle();
    idle();
    iss_ready = 2'b01;
    cycle();
    cycle();

    // fill to 15, writes ignored while full, then free one
    for (int c = 0; c < 7; c++) begin
      set_wr(0, 10 + 2*c, c, c + 1, 1, 1);
      set_wr(1, 11 + 2*c, c + 2, c + 3, 1, 1);
      cycle();
    end
    idle();
    set_wr(0, 24, 1, 1, 1, 1);
    cycle();
    idle();
    set_wr(0, 25, 1, 1, 1, 1);
    set_wr(1, 26, 1, 1, 1, 1);
    cycle();
    idle();
    cycle();
    iss_ready = 2'b01;
    cycle();
    idle();
    cycle();
    iss_ready = 2'b11;
    repeat (8) cycle();
    idle();

    // flush with concurrent write and issue
    for (int c = 0; c < 4; c++) begin
      set_wr(0, 30 + 2*c, 2, 3, 1, 1);
      set_wr(1, 31 + 2*c, 4, 5, 1, 1);
      cycle();
    end
    idle();
    cycle();
    flush = 1'b1;
    iss_ready = 2'b11;
    set_wr(0, 38, 1, 1, 1, 1);
    set_wr(1, 39, 1, 1, 1, 1);
    cycle();
    idle();
    cycle();

    // only port 1 ready
    set_wr(0, 40, 1, 2, 1, 1);
    set_wr(1, 41, 3, 4, 1, 1);
    cycle();
    idle();
    iss_ready = 2'b10;
    cycle();
    idle();
    cycle();
    iss_ready = 2'b11;
    cycle();
    idle();
    cycle();

    // randomized traffic with wrap, flush and mid-traffic reset
    seq = 100;
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom % 200) == 0;
      flush = ($urandom % 90) == 0;
      fl = (QLEN - mdl.size()) < WN;
      ms = min_seq(seq);
      nseq = seq;
      for (int p = 0; p < WN; p++) begin
        if ($urandom % 4 != 0) begin
          nseq = nseq + 1 + int'($urandom % 2);
          if (nseq - ms < 50) begin
            set_wr(p, nseq, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   bit'($urandom % 2), bit'($urandom % 2));
            if (!fl) seq = nseq;
          end
        end
      end
      for (int j = 0; j < KN; j++) begin
        wake_valid[j] = bit'($urandom % 2);
        wake_id[j]    = PW'($urandom_range(0, 15));
      end
      iss_ready = IN'($urandom % 4);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
